uart_rx_byte: RTL and testbench
===============================

Name: uart_rx_byte

Overview:
- 8N1 UART receiver: the receive path complementing the existing byte transmitter that drives uart_rxd_out.
- Samples the host's serial line uart_txd_in, recovers bytes LSB-first, and presents each byte on a valid/ready handshake to on-chip logic (e.g. the CPU I/O port).
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit (100 MHz / 115200 baud); must be >= 4; synthesis-time only.
- SYNC_STAGES, 2, number of flip-flops in the input synchroniser; must be >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- uart_txd_in  input  1  asynchronous serial line from host; idles high.
- data_out  output  8  received byte; stable while valid=1.
- valid  output  1  data_out holds an unconsumed byte.
- ready  input  1  consumer accepts data_out on a clk edge where valid&ready.
- busy  output  1  FSM not in IDLE (a frame is in progress).
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while valid=1 and ready=0; that new byte is dropped.

Behaviour:
- Reset (rst=1 at edge):
  - Synchroniser flops set to 1; FSM goes to IDLE; bit and clock counters go to 0.
  - data_out=8'h00, valid=0, busy=0, frame_err=0, overrun=0.
  - Reset mid-frame abandons the frame silently and drops any held byte.
- All decisions use rx_s, the last synchroniser stage; this gives SYNC_STAGES cycles of input latency.
- Clock counter cnt has width clog2(CLKS_PER_BIT) and is cleared on every state entry.
- IDLE:
  - When rx_s=0, go to START with cnt=0.
- START:
  - Count up. When cnt = CLKS_PER_BIT/2 - 1 (integer division), sample rx_s.
  - If rx_s=0, the start bit is valid: go to DATA with cnt=0 and bit index 0.
  - If rx_s=1, treat as a glitch: return to IDLE with no pulse.
- DATA:
  - When cnt = CLKS_PER_BIT - 1, sample rx_s into shift bit [index], LSB first, and reset cnt.
  - After index 7 is sampled, go to STOP.
- STOP:
  - When cnt = CLKS_PER_BIT - 1, sample rx_s.
  - If rx_s=1, complete the byte (see Output register) and go to IDLE.
  - If rx_s=0, pulse frame_err on the next cycle, discard the byte, and go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rx_s=1, then go to IDLE. This prevents a break condition (line held low) from being re-detected as repeated starts.
- Sampling instants therefore fall at mid-bit (about half a bit after the detected falling edge, then every CLKS_PER_BIT).
- busy=1 in START, DATA, STOP and WAIT_HIGH.
- Output register (evaluated at the stop-sample edge, "complete"):
  - valid=0: load data_out, valid=1.
  - valid=1, ready=1: load the new byte, valid stays 1; the old byte counts as consumed.
  - valid=1, ready=0: keep the old data_out, pulse overrun for one cycle.
  - No completion, valid&ready: valid=0, and data_out holds its value.
- valid asserts on the edge following the stop-sample edge (registered).
- frame_err and overrun are registered, exactly one cycle wide, and mutually exclusive per frame.
- The next start bit may be detected as soon as the FSM is in IDLE, i.e. from the second half of the stop bit onward.

Test Plan (CLKS_PER_BIT=16, SYNC_STAGES=2, 10 ns clk):
- Reset held 3 cycles, line high -> data_out=8'h00, valid=0, busy=0, no pulses; on release, valid stays 0 for 500 cycles.
- Send 8'h2A as an ideal 8N1 frame, ready=0 -> valid rises between 153 and 157 cycles after the falling start edge; data_out=8'h2A; valid holds until ready=1 for one cycle, then drops the next edge.
- 5-cycle low glitch on idle line -> busy pulses briefly, returns to IDLE; no valid, frame_err or overrun.
- Frame 8'h55 with stop bit driven low, then line held low 40 cycles -> frame_err one-cycle pulse, valid stays 0; no new START until the line returns high; a following 8'hA5 frame is received correctly.
- Back-to-back 8'h01, 8'h02 with ready=0 -> 8'h01 is held, overrun pulses once at the second completion, data_out stays 8'h01.
- Repeat with ready=1 held throughout -> both bytes appear in order, no overrun.
- Assert rst mid-DATA of a frame -> all outputs return to reset values next edge; after release, a fresh 8'hC3 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronises the host line, recovers LSB-first bytes,
// and offers them on a valid/ready handshake with framing/overrun pulses.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_txd_in,
  output logic [7:0] data_out,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   complete;

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], uart_txd_in};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    shift_d  = shift_q;
    complete = 1'b0;
    ferr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // a start bit still low at mid-bit is real; otherwise a glitch
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // a full holding register with no taker drops the new byte
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (complete) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: ideal 8N1 frames at 16 clk/bit, random bytes,
// and a frame-level model of the holding register.
module tb_uart_rx_byte;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       line;
  logic       ready;
  logic [7:0] data_out;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad   = 0;
  int fe_n  = 0;
  int ov_n  = 0;
  int vcyc  = 0;
  int busy_n = 0;
  logic [7:0] got_q[$];

  uart_rx_byte #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .uart_txd_in(line),
    .data_out(data_out),
    .valid(valid),
    .ready(ready),
    .busy(busy),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_n++;
    if (overrun) ov_n++;
    if (valid) vcyc++;
    if (busy) busy_n++;
    if (valid && ready) got_q.push_back(data_out);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    line = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      tick(CPB);
    end
    line = stop;
    tick(CPB);
  endtask

  task automatic drain();
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    line = 1'b1;
    ready = 1'b0;
    tick(3);
    total++;
    if (data_out !== 8'h00) begin
      bad++; $display("FAIL rst_data got %h exp 00", data_out);
    end
    total++;
    if (valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid got %b exp 0", valid);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL rst_busy got %b exp 0", busy);
    end
    total++;
    if (frame_err !== 1'b0) begin
      bad++; $display("FAIL rst_ferr got %b exp 0", frame_err);
    end
    total++;
    if (overrun !== 1'b0) begin
      bad++; $display("FAIL rst_ovr got %b exp 0", overrun);
    end
    rst = 1'b0;
    vcyc = 0;
    fe_n = 0;
    ov_n = 0;
    tick(500);
    total++;
    if (vcyc !== 0) begin
      bad++; $display("FAIL idle_valid got %0d cycles exp 0", vcyc);
    end
  endtask

  task automatic test_single();
    int lat;
    int fe0 = fe_n;
    int ov0 = ov_n;
    got_q = {};
    ready = 1'b0;
    lat = -1;
    fork
      send_frame(8'h2A, 1'b1);
      begin
        for (int i = 1; i <= 200; i++) begin
          tick(1);
          if (valid) begin
            lat = i;
            break;
          end
        end
      end
    join
    total++;
    if (lat < 153 || lat > 157) begin
      bad++; $display("FAIL latency got %0d exp 153..157", lat);
    end
    tick(20);
    total++;
    if (valid !== 1'b1 || data_out !== 8'h2A) begin
      bad++; $display("FAIL hold got v=%b %h exp v=1 2a", valid, data_out);
    end
    drain();
    total++;
    if (valid !== 1'b0 || data_out !== 8'h2A) begin
      bad++; $display("FAIL consume got v=%b %h exp v=0 2a", valid, data_out);
    end
    total++;
    if (got_q.size() != 1 || got_q[0] !== 8'h2A) begin
      bad++; $display("FAIL accepted got n=%0d exp one 2a", got_q.size());
    end
    total++;
    if (fe_n != fe0 || ov_n != ov0) begin
      bad++; $display("FAIL single_pulses got fe=%0d ov=%0d exp 0", fe_n - fe0, ov_n - ov0);
    end
  endtask

  task automatic test_glitch();
    int b0 = busy_n;
    int v0 = vcyc;
    int fe0 = fe_n;
    int ov0 = ov_n;
    line = 1'b0;
    tick(5);
    line = 1'b1;
    tick(40);
    total++;
    if (busy_n <= b0 || busy !== 1'b0) begin
      bad++; $display("FAIL glitch_busy got cyc=%0d now=%b exp >0 and 0", busy_n - b0, busy);
    end
    total++;
    if (vcyc != v0 || fe_n != fe0 || ov_n != ov0) begin
      bad++; $display("FAIL glitch_out got v=%0d fe=%0d ov=%0d exp 0", vcyc - v0, fe_n - fe0, ov_n - ov0);
    end
  endtask

  task automatic test_frame_err();
    int fe0 = fe_n;
    int ov0 = ov_n;
    int v0 = vcyc;
    ready = 1'b0;
    send_frame(8'h55, 1'b0);
    tick(40);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL break_busy got %b exp 1", busy);
    end
    line = 1'b1;
    tick(200);
    total++;
    if (fe_n - fe0 != 1) begin
      bad++; $display("FAIL ferr_pulse got %0d cycles exp 1", fe_n - fe0);
    end
    total++;
    if (vcyc != v0 || ov_n != ov0 || busy !== 1'b0) begin
      bad++; $display("FAIL ferr_quiet got v=%0d ov=%0d busy=%b exp 0", vcyc - v0, ov_n - ov0, busy);
    end
    send_frame(8'hA5, 1'b1);
    tick(2);
    total++;
    if (valid !== 1'b1 || data_out !== 8'hA5) begin
      bad++; $display("FAIL after_ferr got v=%b %h exp v=1 a5", valid, data_out);
    end
    drain();
  endtask

  task automatic test_overrun(input logic [7:0] a, input logic [7:0] b);
    int fe0 = fe_n;
    int ov0 = ov_n;
    got_q = {};
    ready = 1'b0;
    send_frame(a, 1'b1);
    send_frame(b, 1'b1);
    tick(2);
    total++;
    if (valid !== 1'b1 || data_out !== a) begin
      bad++; $display("FAIL ovr_hold got v=%b %h exp v=1 %h", valid, data_out, a);
    end
    total++;
    if (ov_n - ov0 != 1 || fe_n != fe0) begin
      bad++; $display("FAIL ovr_pulse got ov=%0d fe=%0d exp 1 0", ov_n - ov0, fe_n - fe0);
    end
    drain();
    total++;
    if (got_q.size() != 1 || got_q[0] !== a) begin
      bad++; $display("FAIL ovr_drain got n=%0d exp one %h", got_q.size(), a);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] sent[$];
    int ov0 = ov_n;
    got_q = {};
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = (i == 0) ? 8'h01 : (i == 1) ? 8'h02 : 8'($urandom);
      sent.push_back(b);
      send_frame(b, 1'b1);
    end
    tick(5);
    ready = 1'b0;
    total++;
    if (got_q.size() != 4 || ov_n != ov0) begin
      bad++; $display("FAIL stream_count got n=%0d ov=%0d exp 4 0", got_q.size(), ov_n - ov0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got_q[i] !== sent[i]) begin
          bad++; $display("FAIL stream_byte%0d got %h exp %h", i, got_q[i], sent[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic       held;
    logic [7:0] held_b;
    int         exp_ov;
    int         ov0 = ov_n;
    got_q = {};
    held = 1'b0;
    held_b = 8'h00;
    exp_ov = 0;
    for (int k = 0; k < 10; k++) begin
      logic [7:0] b;
      logic       r;
      b = 8'($urandom);
      r = 1'($urandom_range(0, 1));
      ready = r;
      if (r && held) begin
        exp_q.push_back(held_b);
        held = 1'b0;
      end
      if (r) exp_q.push_back(b);
      else if (held) exp_ov++;
      else begin
        held = 1'b1;
        held_b = b;
      end
      tick($urandom_range(0, 20));
      send_frame(b, 1'b1);
    end
    ready = 1'b1;
    tick(3);
    ready = 1'b0;
    if (held) exp_q.push_back(held_b);
    total++;
    if (ov_n - ov0 != exp_ov) begin
      bad++; $display("FAIL rand_ovr got %0d exp %0d", ov_n - ov0, exp_ov);
    end
    total++;
    if (got_q != exp_q) begin
      bad++; $display("FAIL rand_bytes got n=%0d exp n=%0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    ready = 1'b0;
    send_frame(8'($urandom), 1'b1);
    tick(2);
    line = 1'b0;
    tick(CPB * 3);
    rst = 1'b1;
    tick(1);
    total++;
    if (valid !== 1'b0 || busy !== 1'b0 || data_out !== 8'h00) begin
      bad++; $display("FAIL mid_rst got v=%b b=%b %h exp 0 0 00", valid, busy, data_out);
    end
    total++;
    if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      bad++; $display("FAIL mid_rst_pulse got fe=%b ov=%b exp 0", frame_err, overrun);
    end
    line = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(20);
    send_frame(8'hC3, 1'b1);
    tick(2);
    total++;
    if (valid !== 1'b1 || data_out !== 8'hC3) begin
      bad++; $display("FAIL post_rst got v=%b %h exp v=1 c3", valid, data_out);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun(8'h01, 8'h02);
    test_overrun(8'($urandom), 8'($urandom));
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
